// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: two master request ports plus the shared bridge port of the arbiter
interface bus_arbiter_if;
   logic        m0_req, m1_req;
   logic [31:0] m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic [3:0]  m0_byteen, m1_byteen;
   logic        m0_ack, m1_ack;
   logic        m0_err, m1_err;
   logic [31:0] m_rdata;
   logic [31:0] br_addr, br_wdata, br_rdata;
   logic [3:0]  br_byteen;
   logic        busy;
   modport slave (
      input  m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_byteen, m1_byteen, br_rdata,
      output m0_ack, m1_ack, m0_err, m1_err, m_rdata, br_addr, br_wdata, br_byteen, busy
   );
   modport master (
      output m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_byteen, m1_byteen, br_rdata,
      input  m0_ack, m1_ack, m0_err, m1_err, m_rdata, br_addr, br_wdata, br_byteen, busy
   );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin two-master arbiter with address decode in front of the system bridge
module bus_arbiter #(
   parameter logic [31:0] DM_TOP   = 32'h2fff,
   parameter logic [31:0] TC1_BASE = 32'h7f00,
   parameter logic [31:0] TC2_BASE = 32'h7f10,
   parameter logic [31:0] IG_ADDR  = 32'h7f20
) (
   input logic          clk,
   input logic          reset,
   bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   state_t      state, state_nx;
   logic        last, win, win_nx, grant;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  byteen;
   logic        tc_hit, mapped, err;
   // next-state, arbitration and decode of the latched transaction
   always_comb begin
      grant    = bus.m0_req | bus.m1_req;
      win_nx   = bus.m1_req & (~bus.m0_req | ~last);
      state_nx = state == IDLE ? (grant ? ISSUE : IDLE) : state == ISSUE ? RESP : IDLE;
      tc_hit   = (addr >= TC1_BASE && addr <= TC1_BASE + 32'hb) ||
                 (addr >= TC2_BASE && addr <= TC2_BASE + 32'hb);
      mapped   = addr <= DM_TOP || tc_hit || addr == IG_ADDR;
      err      = ~mapped | (tc_hit & byteen != 4'h0 & byteen != 4'hf);
   end
   // state register; reset returns to IDLE at once so an in-flight write is dropped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else state <= state_nx;
   end
   // winner latches, read capture and round-robin pointer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win    <= 1'b0;
         addr   <= '0;
         wdata  <= '0;
         byteen <= '0;
         rdata  <= '0;
         last   <= 1'b1;
      end else begin
         if (state == IDLE && grant) begin
            win    <= win_nx;
            addr   <= win_nx ? bus.m1_addr : bus.m0_addr;
            wdata  <= win_nx ? bus.m1_wdata : bus.m0_wdata;
            byteen <= win_nx ? bus.m1_byteen : bus.m0_byteen;
         end
         if (state == ISSUE) rdata <= err ? '0 : bus.br_rdata;
         if (state == RESP) last <= win;
      end
   end
   assign bus.br_addr   = addr;
   assign bus.br_wdata  = wdata;
   assign bus.br_byteen = (state == ISSUE && !err) ? byteen : 4'h0;
   assign bus.m0_ack    = state == RESP && !win;
   assign bus.m1_ack    = state == RESP && win;
   assign bus.m0_err    = bus.m0_ack & err;
   assign bus.m1_err    = bus.m1_ack & err;
   assign bus.m_rdata   = rdata;
   assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed plus randomized transaction checks against a transaction-level model
module tb_bus_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;
   bus_arbiter_if bus ();
   bus_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
   logic        r [2];
   logic [31:0] a [2];
   logic [31:0] w [2];
   logic [3:0]  b [2];
   logic        fix_rd;
   int          last_m, checks, failures;
   int          grants[$];
   logic [31:0] pool [15] = '{32'h0, 32'h10, 32'h2ffc, 32'h2fff, 32'h3000, 32'h7eff, 32'h7f00, 32'h7f04,
                              32'h7f0b, 32'h7f0c, 32'h7f10, 32'h7f1b, 32'h7f1c, 32'h7f20, 32'h7f24};
   // bridge read data is a fixed function of the address unless a fixed word is forced
   function automatic logic [31:0] rd_of(input logic [31:0] x);
      return {x[15:0], ~x[15:0]};
   endfunction
   function automatic logic err_of(input logic [31:0] x, input logic [3:0] be);
      logic tmr;
      tmr = (x >= 32'h7f00 && x <= 32'h7f0b) || (x >= 32'h7f10 && x <= 32'h7f1b);
      return !(x <= 32'h2fff || tmr || x == 32'h7f20) || (tmr && be != 4'h0 && be != 4'hf);
   endfunction
   function automatic logic [31:0] pick_addr();
      int k;
      k = $urandom_range(0, 15);
      return k == 15 ? 32'($urandom_range(0, 32'hffff)) : pool[k];
   endfunction
   function automatic logic [3:0] pick_be();
      int k;
      k = $urandom_range(0, 2);
      return k == 0 ? 4'h0 : k == 1 ? 4'hf : 4'($urandom_range(0, 15));
   endfunction
   assign bus.m0_req    = r[0];
   assign bus.m1_req    = r[1];
   assign bus.m0_addr   = a[0];
   assign bus.m1_addr   = a[1];
   assign bus.m0_wdata  = w[0];
   assign bus.m1_wdata  = w[1];
   assign bus.m0_byteen = b[0];
   assign bus.m1_byteen = b[1];
   assign bus.br_rdata  = fix_rd ? 32'hdeadbeef : rd_of(bus.br_addr);
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   // one arbitration round, entered and left on a falling edge while idle;
   // keep: 0 winner drops req, 1 winner keeps req, 2 winner randomly re-requests
   task automatic round(input int keep);
      int          win;
      logic [31:0] ea, ew, erd;
      logic [3:0]  eb;
      logic        eerr;
      chk("idle_busy", bus.busy, 0);
      chk("idle_be", bus.br_byteen, 0);
      chk("idle_ack", {bus.m0_ack, bus.m1_ack}, 0);
      if (!r[0] && !r[1]) begin
         @(negedge clk);
         chk("noreq_busy", bus.busy, 0);
         return;
      end
      win  = (r[0] && r[1]) ? (last_m == 1 ? 0 : 1) : (r[1] ? 1 : 0);
      ea   = a[win];
      ew   = w[win];
      eb   = b[win];
      eerr = err_of(ea, eb);
      erd  = eerr ? 32'h0 : (fix_rd ? 32'hdeadbeef : rd_of(ea));
      @(negedge clk);
      a[win] = $urandom;
      w[win] = $urandom;
      b[win] = 4'($urandom_range(0, 15));
      #1;
      chk("issue_busy", bus.busy, 1);
      chk("issue_be", bus.br_byteen, eerr ? 4'h0 : eb);
      if (!eerr) begin
         chk("issue_addr", bus.br_addr, ea);
         chk("issue_wdata", bus.br_wdata, ew);
      end
      chk("issue_ack", {bus.m0_ack, bus.m1_ack}, 0);
      @(negedge clk);
      chk("resp_ack0", bus.m0_ack, win == 0);
      chk("resp_ack1", bus.m1_ack, win == 1);
      chk("resp_err", win ? bus.m1_err : bus.m0_err, eerr);
      chk("resp_err_other", win ? bus.m0_err : bus.m1_err, 0);
      chk("resp_rdata", bus.m_rdata, erd);
      chk("resp_be", bus.br_byteen, 0);
      last_m = win;
      grants.push_back(win);
      if (keep == 0) r[win] = 1'b0;
      if (keep == 2) begin
         r[win] = 1'($urandom_range(0, 1));
         a[win] = pick_addr();
         w[win] = $urandom;
         b[win] = pick_be();
      end
      @(negedge clk);
   endtask
   task automatic single(input int m, input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] be);
      r[m] = 1'b1;
      a[m] = ad;
      w[m] = wd;
      b[m] = be;
      round(0);
   endtask
   initial begin
      r = '{1'b0, 1'b0};
      a = '{32'h0, 32'h0};
      w = '{32'h0, 32'h0};
      b = '{4'h0, 4'h0};
      fix_rd = 1'b0;
      last_m = 1;
      checks = 0;
      failures = 0;
      @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_be", bus.br_byteen, 0);
      chk("rst_ack", {bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err}, 0);
      chk("rst_rdata", bus.m_rdata, 0);
      chk("rst_addr", bus.br_addr, 0);
      reset = 1'b1;
      fix_rd = 1'b1;
      single(0, 32'h10, 32'h0, 4'h0);
      fix_rd = 1'b0;
      single(1, 32'h7f04, 32'h1234_5678, 4'hf);
      single(1, 32'h7f04, 32'h1234_5678, 4'h3);
      single(0, 32'h2ffc, 32'h0, 4'h0);
      single(0, 32'h3000, 32'h0, 4'h0);
      single(1, 32'h7f20, 32'h5555_aaaa, 4'hf);
      single(1, 32'h7f24, 32'h5555_aaaa, 4'hf);
      single(0, 32'h7f0c, 32'h1, 4'hf);
      single(0, 32'h7f1b, 32'h0, 4'h0);
      single(1, 32'h20, 32'hcafe_0001, 4'h1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      last_m = 1;
      grants.delete();
      r = '{1'b1, 1'b1};
      a = '{32'h100, 32'h200};
      b = '{4'h0, 4'h0};
      repeat (4) round(1);
      for (int i = 0; i < 4; i++) chk("contention_grant", grants[i], i % 2);
      r = '{1'b0, 1'b0};
      @(negedge clk);
      r[0] = 1'b1;
      a[0] = 32'h100;
      w[0] = 32'h0bad_f00d;
      b[0] = 4'hf;
      @(posedge clk);
      #2;
      chk("pre_rst_be", bus.br_byteen, 4'hf);
      reset = 1'b0;
      #1;
      chk("rst_issue_be", bus.br_byteen, 0);
      chk("rst_issue_busy", bus.busy, 0);
      @(posedge clk);
      #1;
      chk("rst_issue_ack", bus.m0_ack, 0);
      @(negedge clk);
      reset = 1'b1;
      last_m = 1;
      round(0);
      r[0] = 1'b1;
      a[0] = 32'h10;
      b[0] = 4'h0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_ack", bus.m0_ack, 1);
      reset = 1'b0;
      #1;
      chk("rst_resp_ack", bus.m0_ack, 0);
      r[0] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      last_m = 1;
      repeat (200) begin
         for (int m = 0; m < 2; m++)
            if (!r[m] && $urandom_range(0, 1) == 1) begin
               r[m] = 1'b1;
               a[m] = pick_addr();
               w[m] = $urandom;
               b[m] = pick_be();
            end
         round(2);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
